// File: rtl/am_demod_scheduler.sv
// Round-robin scheduler sharing one sqrt(I^2+Q^2) engine across NUM_CH channels.
// Define AM_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration.
module am_demod_scheduler #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_inphase,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_quadrature,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         busy
);

  localparam int DW = DATA_WIDTH;
  localparam int N  = 2*DW + 2;
  localparam int H  = N / 2;
  localparam int RW = H + 2;
  localparam int IW = $clog2(H);

  typedef enum logic [2:0] {
    IDLE, SQ_I, SQ_Q, ROOT, DONE
  } state_t;

  state_t state, state_nxt;

  logic [CH_W-1:0]      last_grant;
  logic [CH_W-1:0]      grant;
  logic                 found;
  logic [CH_W-1:0]      ch_q;
  logic signed [DW-1:0] i_q;
  logic signed [DW-1:0] q_q;
  logic [N-1:0]         acc;
  logic [N-1:0]         a;
  logic [RW-1:0]        r;
  logic [H-1:0]         qr;
  logic [IW-1:0]        iter;
  logic [DW-1:0]        data_q;

  logic signed [DW-1:0]   mul_op;
  logic signed [2*DW-1:0] prod;
  logic [N-1:0]           sum;
  logic [RW-1:0]          left, right, r_nxt;
  logic [H-1:0]           qr_nxt;
  logic                   last_iter;

  always_comb begin
    grant = '0;
    found = 1'b0;
`ifdef AM_SCHED_FIXED_PRIO_EN
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (in_valid[i]) begin
        grant = CH_W'(i);
        found = 1'b1;
      end
    end
`else
    for (int i = 1; i <= NUM_CH; i++) begin
      int idx;
      idx = int'(last_grant) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && in_valid[CH_W'(idx)]) begin
        grant = CH_W'(idx);
        found = 1'b1;
      end
    end
`endif
  end

  // Single multiplier: I in SQ_I, Q in SQ_Q; squares are never negative.
  assign mul_op = (state == SQ_Q) ? q_q : i_q;
  assign prod   = mul_op * mul_op;
  assign sum    = acc + {2'b00, prod};

  assign left      = {r[H-1:0], a[N-1:N-2]};
  assign right     = {qr, r[RW-1], 1'b1};
  assign r_nxt     = r[RW-1] ? left + right : left - right;
  assign qr_nxt    = {qr[H-2:0], ~r_nxt[RW-1]};
  assign last_iter = (iter == IW'(H-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (found)     state_nxt = SQ_I;
      SQ_I:                state_nxt = SQ_Q;
      SQ_Q:                state_nxt = ROOT;
      ROOT: if (last_iter) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = '0;
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    if (state == IDLE && found) in_ready[grant] = 1'b1;
  end

  assign out_data = data_q;
  assign out_ch   = ch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= CH_W'(NUM_CH-1);
      ch_q       <= '0;
      i_q        <= '0;
      q_q        <= '0;
      acc        <= '0;
      a          <= '0;
      r          <= '0;
      qr         <= '0;
      iter       <= '0;
      data_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            last_grant <= grant;
            ch_q       <= grant;
            i_q        <= in_inphase[grant*DW +: DW];
            q_q        <= in_quadrature[grant*DW +: DW];
          end
        end
        SQ_I: acc <= {2'b00, prod};
        SQ_Q: begin
          acc  <= {1'b0, sum[N-2:0]};
          a    <= {1'b0, sum[N-2:0]};
          r    <= '0;
          qr   <= '0;
          iter <= '0;
        end
        ROOT: begin
          r    <= r_nxt;
          qr   <= qr_nxt;
          a    <= a << 2;
          iter <= iter + 1'b1;
          if (last_iter) data_q <= qr_nxt[DW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_am_demod_scheduler.sv
// Directed bench for am_demod_scheduler.
// Expected values are hand-computed magnitudes.
module tb_am_demod_scheduler;

  localparam int DW = 12;
  localparam int NC = 4;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     in_valid;
  logic [NC-1:0]     in_ready;
  logic [NC*DW-1:0]  in_inphase;
  logic [NC*DW-1:0]  in_quadrature;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic              busy;

  int passed = 0;
  int total  = 0;

  am_demod_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inphase    (in_inphase),
    .in_quadrature (in_quadrature),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_ch        (out_ch),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic set_ch(input int ch, input int iv, input int qv);
    in_inphase[ch*DW +: DW]    = DW'(iv);
    in_quadrature[ch*DW +: DW] = DW'(qv);
  endtask

  // Count negedges until out_valid, bounded.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
  endtask

  // Single request; called at a negedge while idle.
  task automatic run_one(input string tag, input int ch, input int iv,
                         input int qv, input int exp);
    int n;
    set_ch(ch, iv, qv);
    in_valid = NC'(1) << ch;
    #1;
    chk({tag, "_rdy"}, int'(in_ready), 1 << ch);
    @(negedge clk);
    in_valid = '0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 16);
    chk({tag, "_data"}, int'(out_data), exp);
    chk({tag, "_ch"}, int'(out_ch), ch);
  endtask

  initial begin
    int n;
    int exp_ch;
    rst_n         = 1'b0;
    in_valid      = '0;
    in_inphase    = '0;
    in_quadrature = '0;
    out_ready     = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ch", int'(out_ch), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rdy", int'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one("t1", 0, 3, 4, 5);
    @(negedge clk);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_valid_after", int'(out_valid), 0);
    chk("t1_data_hold", int'(out_data), 5);

    run_one("t2a", 2, -2048, -2048, 2896);
    @(negedge clk);
    run_one("t2b", 1, 0, 0, 0);
    @(negedge clk);

    // Fresh pointer, all channels requesting continuously.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NC; k++) set_ch(k, k + 1, 0);
    in_valid = '1;
    for (int j = 0; j < 5; j++) begin
      wait_out(n);
`ifdef AM_SCHED_FIXED_PRIO_EN
      exp_ch = 0;
`else
      exp_ch = j % NC;
`endif
      chk($sformatf("t3_gap%0d", j), n, (j == 0) ? 16 : 17);
      chk($sformatf("t3_ch%0d", j), int'(out_ch), exp_ch);
      chk($sformatf("t3_data%0d", j), int'(out_data), exp_ch + 1);
      if (j == 4) in_valid = '0;
    end
    @(negedge clk);

    // Backpressure with other channels requesting.
    out_ready = 1'b0;
    set_ch(3, 5, 12);
    set_ch(0, 6, 8);
    in_valid = 4'b1000;
    #1;
    chk("t4_rdy", int'(in_ready), 4'b1000);
    @(negedge clk);
    in_valid = 4'b0111;
    wait_out(n);
    chk("t4_lat", n + 1, 16);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t4_hold_v%0d", k), int'(out_valid), 1);
      chk($sformatf("t4_hold_d%0d", k), int'(out_data), 13);
      chk($sformatf("t4_hold_c%0d", k), int'(out_ch), 3);
      chk($sformatf("t4_hold_r%0d", k), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_rel_valid", int'(out_valid), 0);
    chk("t4_rel_data", int'(out_data), 13);
    chk("t4_rel_busy", int'(busy), 0);
    chk("t4_next_rdy", int'(in_ready), 4'b0001);

    // Abort in ROOT: ch0 accepted above, reset at T+8.
    @(negedge clk);
    in_valid = '0;
    repeat (7) @(negedge clk);
    chk("t5_in_root", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = '1;
    #1;
    chk("t5_regrant", int'(in_ready), 4'b0001);
    @(negedge clk);
    in_valid = '0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_lat", n, 16);
    chk("t5_ch", int'(out_ch), 0);
    chk("t5_data", int'(out_data), 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/am_demod_scheduler.md
Name: am_demod_scheduler

Overview:
- Shares one multi-cycle magnitude engine, sqrt(I^2 + Q^2), between NUM_CH I/Q channels feeding the AM demod stage.
- A valid/ready round-robin arbiter picks one channel at a time.
- One multiplier is time-shared to form I^2 then Q^2. The square root is computed iteratively, one result bit per cycle, using the non-restoring algorithm.
- Intended for multi-channel receivers where per-channel sample rates are far below clk.

Parameters:
- DATA_WIDTH, 12: I/Q sample width (signed) and demod output width (unsigned).
- NUM_CH, 4: number of requesting channels, at least 2. CH_W = $clog2(NUM_CH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_CH  per-channel request; bit k belongs to channel k.
- in_ready  out  NUM_CH  per-channel accept, one-hot or zero.
- in_inphase  in  NUM_CH*DATA_WIDTH  signed I; channel k at [k*DATA_WIDTH +: DATA_WIDTH].
- in_quadrature  in  NUM_CH*DATA_WIDTH  signed Q, packed the same way.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  magnitude, unsigned.
- out_ch  out  CH_W  channel index of out_data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - state=IDLE; out_valid=0, out_data=0, out_ch=0, busy=0, in_ready=0.
  - Round-robin pointer last_grant=NUM_CH-1, so channel 0 has top priority.
  - All internal accumulators are cleared.
- IDLE:
  - If any in_valid bit is set, grant = first set bit searching upward from last_grant+1, modulo NUM_CH.
  - in_ready[grant] is driven combinationally in the same cycle; that cycle is the handshake.
  - Capture I, Q and grant; set last_grant=grant; go to SQ_I. No grant occurs if in_valid=0.
  - in_ready is 0 in every other state.
- SQ_I: acc <= I*I (2*DATA_WIDTH bits, signed product, always non-negative). Go to SQ_Q.
- SQ_Q:
  - acc <= {1'b0, acc + Q*Q}, giving N = 2*DATA_WIDTH+2 bits. The forced 0 MSB makes the width even.
  - Load radicand a=acc+Q*Q; set q=0, r=0, iter=0. Go to ROOT.
- ROOT: N/2 = DATA_WIDTH+1 cycles, one iteration per cycle.
  - r is N/2+2 bits; its MSB is the sign.
  - left = {r[N/2-1:0], a[N-1:N-2]}; right = {q, r[MSB], 1'b1}.
  - r <= r[MSB] ? left+right : left-right.
  - q <= {q[N/2-2:0], ~r_next[MSB]}; a <= a<<2.
  - After iter = N/2-1, go to DONE.
- DONE:
  - out_valid=1, out_data = low DATA_WIDTH bits of q, out_ch = captured channel.
  - Max result for DW=12 is 2896, so it never overflows.
  - out_data and out_ch stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, go to IDLE the next cycle; out_valid drops to 0 and out_data holds its value.
- Timing:
  - Latency: accept at cycle T, out_valid first high at T+DATA_WIDTH+4 (16 for the default).
  - Peak throughput, with out_ready held high: one sample per DATA_WIDTH+5 cycles.
- Boundary conditions:
  - in_valid deasserted by a requester while not granted: no effect; requesters must hold I/Q until in_ready.
  - A simultaneous request from the just-served channel loses to any other requester under round-robin.
  - Reset mid-operation aborts immediately. The in-flight sample is discarded and no out_valid follows.
  - I or Q = -2^(DATA_WIDTH-1) is legal; its square is positive.

Optional Feature:
- Macro AM_SCHED_FIXED_PRIO_EN.
- Defined: the grant is always the lowest-index set in_valid bit; last_grant is ignored but still updated. Ports are unchanged.
- Undefined (default): round-robin as described above.

Test Plan:
- Ch0 valid with I=3, Q=4, out_ready=1: in_ready[0] pulses at T; out_valid at T+16 with out_data=5 and out_ch=0; busy is low at T+17.
- Ch2 valid with I=-2048, Q=-2048: out_data=2896, out_ch=2. Ch1 with I=0, Q=0: out_data=0.
- All 4 channels valid continuously with distinct I/Q (ch k: I=k+1, Q=0): outputs arrive in order ch0, ch1, ch2, ch3, ch0, each 17 cycles apart. With AM_SCHED_FIXED_PRIO_EN defined: ch0 every time.
- Ch3 with I=5, Q=12, out_ready held low for 6 cycles after out_valid: out_valid, out_data=13 and out_ch=3 stay stable; no in_ready pulses while other channels request. Release: one transfer, then IDLE.
- rst_n pulsed low during ROOT (cycle T+8): out_valid stays 0, state returns to IDLE, and the next grant with all channels valid goes to ch0.
